// File: rtl/timer_dev_pkg.sv
// ---------------------------------------------------------------------------
// timer_dev_pkg
// Shared constants for the timer device: register offsets (word index taken
// from addr[3:2]), CTRL bit positions, mode codes, FSM state encoding and the
// device base addresses used by the system-level bus decoder.
// ---------------------------------------------------------------------------
package timer_dev_pkg;

   // Register offsets as word index (byte offsets 0x0 / 0x4 / 0x8 / 0xC)
   localparam logic [1:0] OFF_CTRL     = 2'b00;
   localparam logic [1:0] OFF_PRESET   = 2'b01;
   localparam logic [1:0] OFF_COUNT    = 2'b10;
   localparam logic [1:0] OFF_RESERVED = 2'b11;

   // CTRL bit positions
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM_BIT  = 3;
   localparam int CTRL_WIDTH   = 4;

   // Mode codes; 10 and 11 behave as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Device base addresses, decoded outside timer_dev
   localparam logic [31:0] TIMER0_BASE = 32'h0000_7f00;
   localparam logic [31:0] TIMER1_BASE = 32'h0000_7f10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } timerState_e;

   // Saturating decrement: the count never wraps below zero
   function automatic logic [31:0] decCount(input logic [31:0] value);
      return (value > 32'd1) ? (value - 32'd1) : 32'd0;
   endfunction

endpackage

// File: rtl/timer_dev.sv
// ---------------------------------------------------------------------------
// timer_dev
// Memory-mapped down-counting timer with a level interrupt. One instance per
// timer (Timer0 at 0x7f00, Timer1 at 0x7f10); only the offset bits addr[3:2]
// are decoded here.
//
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   reset  in   1   synchronous active-high reset
//   addr   in  30   word address [31:2]; [3:2] select CTRL/PRESET/COUNT
//   we     in   1   write enable from the bus bridge
//   din    in  32   write data
//   dout   out 32   read data, combinational from addr
//   irq    out  1   interrupt request = IM & irq flag
//
// Build option
//   TIMER_AUTORELOAD_EN  when defined, Mode 01 reloads automatically after
//                        each expiry and pulses irq for one cycle. When not
//                        defined the Mode bits are stored and readable but
//                        every mode behaves as one-shot.
// ---------------------------------------------------------------------------
module timer_dev
   import timer_dev_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   logic [CTRL_WIDTH-1:0] r_ctrl;
   logic [31:0]           r_preset;
   logic [31:0]           r_count;
   logic                  r_irqFlag;
   timerState_e           r_state;

   logic [1:0] w_off;
   logic       w_ctrlWrite;
   logic       w_presetWrite;
   logic       w_enable;
   logic       w_reload;
   logic       w_unusedAddr;

   // Bus decode; upper address bits belong to the system decoder
   assign w_off         = addr[3:2];
   assign w_unusedAddr  = ^addr[31:4];
   assign w_ctrlWrite   = we && (w_off == OFF_CTRL);
   assign w_presetWrite = we && (w_off == OFF_PRESET);
   assign w_enable      = r_ctrl[CTRL_EN_BIT];

   // Auto-reload only exists when the build option is enabled
`ifdef TIMER_AUTORELOAD_EN
   assign w_reload = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
`else
   assign w_reload = 1'b0;
`endif

   // Register file and control FSM. The CTRL bus write is placed after the
   // FSM so that, on the same edge, it overrides the FSM clearing Enable and
   // always clears the irq flag. A PRESET write only changes r_preset, so a
   // running count is unaffected until the next LOAD.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl    <= '0;
         r_preset  <= 32'd0;
         r_count   <= 32'd0;
         r_irqFlag <= 1'b0;
         r_state   <= ST_IDLE;
      end else begin
         if (w_presetWrite) begin
            r_preset <= din;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_enable) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_count <= r_preset;
               r_state <= ST_CNT;
            end
            ST_CNT: begin
               if (!w_enable) begin
                  r_state <= ST_IDLE;
               end else if (r_count > 32'd1) begin
                  r_count <= decCount(r_count);
               end else begin
                  r_count   <= 32'd0;
                  r_irqFlag <= 1'b1;
                  r_state   <= ST_INT;
               end
            end
            ST_INT: begin
               if (w_reload) begin
                  r_irqFlag <= 1'b0;
               end else begin
                  r_ctrl[CTRL_EN_BIT] <= 1'b0;
               end
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         if (w_ctrlWrite) begin
            r_ctrl    <= din[CTRL_WIDTH-1:0];
            r_irqFlag <= 1'b0;
         end
      end
   end

   // Read mux; the reserved offset and CTRL upper bits read as zero
   always_comb begin
      dout = 32'd0;
      case (w_off)
         OFF_CTRL:     dout = {{(32-CTRL_WIDTH){1'b0}}, r_ctrl};
         OFF_PRESET:   dout = r_preset;
         OFF_COUNT:    dout = r_count;
         OFF_RESERVED: dout = 32'd0;
         default:      dout = 32'd0;
      endcase
   end

   // Interrupt is the masked flag
   assign irq = r_ctrl[CTRL_IM_BIT] & r_irqFlag;

endmodule

// File: tb/tb_timer_dev.sv
// ---------------------------------------------------------------------------
// tb_timer_dev
// Self-checking bench for timer_dev. Each stimulus cycle pushes its expected
// dout/irq onto a scoreboard queue; after the clock edge the entry is popped
// and compared with what the DUT shows for the same address.
// ---------------------------------------------------------------------------
module tb_timer_dev;
   import timer_dev_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   timer_dev dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dout;
      logic        irq;
      int          tag;
   } expect_t;

   typedef struct {
      logic        rst;
      logic        wr;
      logic [1:0]  off;
      logic [31:0] data;
      logic [31:0] expDout;
      logic        expIrq;
   } vector_t;

   expect_t     expQ[$];
   vector_t     vecs[19];
   int          total   = 0;
   int          bad     = 0;
   int          tagNext = 0;
   logic [31:0] baseAddr;

   // Pop the oldest expectation and compare it with the DUT outputs
   task automatic checkOutput();
      expect_t e;
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_empty got dout=%h irq=%b required an entry", dout, irq);
         return;
      end
      e = expQ.pop_front();
      if (dout !== e.dout || irq !== e.irq) begin
         bad++;
         $display("[TB] FAIL chk%0d got dout=%h irq=%b required dout=%h irq=%b",
                  e.tag, dout, irq, e.dout, e.irq);
      end
   endtask

   // Drive one bus cycle, record the expected result, sample after the edge
   task automatic applyStimulus(input logic rst, input logic wr, input logic [1:0] off,
                                input logic [31:0] data, input logic [31:0] expDout,
                                input logic expIrq);
      expect_t e;
      @(negedge clk);
      reset = rst;
      we    = wr;
      addr  = baseAddr[31:2] | {28'd0, off};
      din   = data;
      e.dout = expDout;
      e.irq  = expIrq;
      e.tag  = tagNext;
      tagNext++;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      reset = 1'b0;
      we    = 1'b0;
      checkOutput();
   endtask

   task automatic readCycle(input logic [1:0] off, input logic [31:0] expDout, input logic expIrq);
      applyStimulus(1'b0, 1'b0, off, 32'd0, expDout, expIrq);
   endtask

   task automatic writeCycle(input logic [1:0] off, input logic [31:0] data,
                             input logic [31:0] expDout, input logic expIrq);
      applyStimulus(1'b0, 1'b1, off, data, expDout, expIrq);
   endtask

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout_reached=1 required=0");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] eCnt[12];
      logic        eIrq[12];
      logic [31:0] finalCtrl;
      logic        finalIrq;
      logic [31:0] model;

      baseAddr = TIMER0_BASE;
      reset    = 1'b1;
      we       = 1'b0;
      din      = 32'd0;
      addr     = baseAddr[31:2];

      // Reset with a competing write, reads of every offset, one-shot
      // countdown from 5, irq hold and clear, reserved and upper-bit writes
      vecs[0]  = '{1'b1, 1'b1, 2'd0, 32'h0000_000F, 32'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'd0,         32'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'd0,         32'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'd0,         32'd0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'd5,         32'd5, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 2'd0, 32'h9,         32'h9, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd5, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd4, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd3, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd2, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 2'd2, 32'd0,         32'd0, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 2'd0, 32'd0,         32'h8, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 2'd0, 32'd0,         32'h8, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 2'd0, 32'h8,         32'h8, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 2'd3, 32'h0000_FFFF, 32'd0, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 2'd0, 32'hFFFF_FFF0, 32'd0, 1'b0};

      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].off, vecs[i].data,
                       vecs[i].expDout, vecs[i].expIrq);
      end

      // Masked interrupt with PRESET=1: INT reached, irq stays low, Enable
      // clears, COUNT write ignored
      writeCycle(2'd1, 32'd1, 32'd1, 1'b0);
      writeCycle(2'd0, 32'h1, 32'h1, 1'b0);
      readCycle(2'd2, 32'd0, 1'b0);
      readCycle(2'd2, 32'd1, 1'b0);
      readCycle(2'd2, 32'd0, 1'b0);
      readCycle(2'd0, 32'd0, 1'b0);
      writeCycle(2'd2, 32'h55, 32'd0, 1'b0);

      // PRESET=10 with PRESET=2 written mid-count: first expiry after 10
      writeCycle(2'd1, 32'd10, 32'd10, 1'b0);
      writeCycle(2'd0, 32'h9, 32'h9, 1'b0);
      for (int k = 1; k <= 13; k++) begin
         if (k == 4) begin
            writeCycle(2'd1, 32'd2, 32'd2, 1'b0);
         end else begin
            model = (k < 2 || k >= 12) ? 32'd0 : 32'(12 - k);
            readCycle(2'd2, model, (k >= 12));
         end
      end
      // Re-enable: reload uses the new PRESET of 2
      writeCycle(2'd0, 32'h9, 32'h9, 1'b0);
      readCycle(2'd2, 32'd0, 1'b0);
      readCycle(2'd2, 32'd2, 1'b0);
      readCycle(2'd2, 32'd1, 1'b0);
      readCycle(2'd2, 32'd0, 1'b1);

      // CTRL write on the INT edge keeps Enable, so a reload follows
      writeCycle(2'd0, 32'h9, 32'h9, 1'b0);
      readCycle(2'd2, 32'd0, 1'b0);
      readCycle(2'd2, 32'd2, 1'b0);
      // Reset mid-count aborts with no irq and no restart
      applyStimulus(1'b1, 1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
      readCycle(2'd0, 32'd0, 1'b0);
      readCycle(2'd2, 32'd0, 1'b0);
      readCycle(2'd1, 32'd0, 1'b0);
      readCycle(2'd2, 32'd0, 1'b0);

      // Enable cleared on the LOAD edge: LOAD completes, CNT returns to IDLE
      writeCycle(2'd1, 32'd3, 32'd3, 1'b0);
      writeCycle(2'd0, 32'h9, 32'h9, 1'b0);
      readCycle(2'd2, 32'd0, 1'b0);
      writeCycle(2'd0, 32'h8, 32'h8, 1'b0);
      readCycle(2'd2, 32'd3, 1'b0);
      readCycle(2'd2, 32'd3, 1'b0);

      // Mode 01 with PRESET=3
`ifdef TIMER_AUTORELOAD_EN
      eCnt = '{32'd3, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
               32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
      eIrq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      finalCtrl = 32'hB;
      finalIrq  = 1'b0;
`else
      eCnt = '{32'd3, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
               32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      eIrq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      finalCtrl = 32'hA;
      finalIrq  = 1'b1;
`endif
      writeCycle(2'd0, 32'hB, 32'hB, 1'b0);
      for (int k = 0; k < 12; k++) begin
         readCycle(2'd2, eCnt[k], eIrq[k]);
      end
      readCycle(2'd0, finalCtrl, finalIrq);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
